// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// opcodes, funct codes, ALU controls and the controller state set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU operation class and the instruction
// funct field onto the datapath ALU control code.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unknown funct codes fall back to add
                case (funct)
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS controller: sequences fetch/decode/execute/memory/
// write-back over a shared datapath with a request/ready memory.
module mc_control_unit
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = ALUOP_ADD;
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXECUTE: begin
                alu_op    = ALUOP_FUNCT;
                alu_src_a = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_op     = ALUOP_SUB;
                alu_src_a  = 1'b1;
                branch     = 1'b1;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // State is already FETCH in reset; only the ready-driven loads need masking
        if (rst) begin
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed and randomized bench for mc_control_unit: a per-cycle
// expected-output table built from the instruction step rules.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, iord, ir_write, pc_write, branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst, mem_to_reg, reg_write, mem_write;
    logic       instr_done, illegal_op;

    int vectors = 0;
    int errors  = 0;
    int cyc;
    int ndone;
    int done_at;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    wire [18:0] obs = {mem_req, iord, ir_write, pc_write, branch, pc_src,
                       alu_src_a, alu_src_b, alu_control, reg_dst,
                       mem_to_reg, reg_write, mem_write, instr_done,
                       illegal_op};

    // Expected output word; unnamed fields are zero
    function automatic logic [18:0] ev(
        input logic mreq, input logic io, input logic irw, input logic pcw,
        input logic br, input logic [1:0] ps, input logic sa,
        input logic [1:0] sb, input logic [2:0] ac, input logic rd,
        input logic m2r, input logic rw, input logic mw, input logic dn,
        input logic il);
        return {mreq, io, irw, pcw, br, ps, sa, sb, ac, rd, m2r, rw, mw,
                dn, il};
    endfunction

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int ref_latency(input logic [5:0] op);
        case (op)
            6'b000000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input logic [18:0] got, input logic [18:0] exp,
                       input string tag);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input int got, input int exp, input string tag);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1
    task automatic step(input logic mr, input logic [18:0] exp,
                        input string tag);
        mem_ready = mr;
        #1;
        chk(obs, exp, tag);
        if (instr_done) ndone++;
        if ((instr_done || illegal_op) && done_at < 0) done_at = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int sf, input int sm, input string nm);
        logic [18:0] rst_like;
        logic        legal;
        logic        is_mem;
        int          lat;
        cyc     = 0;
        ndone   = 0;
        done_at = -1;
        opcode  = op;
        funct   = fn;
        legal   = (ref_latency(op) != 2);
        is_mem  = (op == 6'b100011) || (op == 6'b101011);
        rst_like = ev(1,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,0,0);
        repeat (sf) step(1'b0, rst_like, {nm, "_fetch_stall"});
        step(1'b1, ev(1,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0,0,0),
             {nm, "_fetch"});
        step(rb(), ev(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0,0,!legal),
             {nm, "_decode"});
        case (op)
            6'b000000: begin
                step(rb(), ev(0,0,0,0,0,2'b00,1,2'b00,ref_alu(fn),0,0,0,0,0,0),
                     {nm, "_exec"});
                step(rb(), ev(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,1,0,1,0),
                     {nm, "_aluwb"});
            end
            6'b100011: begin
                step(rb(), ev(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0,0),
                     {nm, "_memadr"});
                repeat (sm)
                    step(1'b0, ev(1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0,0),
                         {nm, "_memrd_stall"});
                step(1'b1, ev(1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0,0),
                     {nm, "_memrd"});
                step(rb(), ev(0,0,0,0,0,2'b00,0,2'b00,3'b010,0,1,1,0,1,0),
                     {nm, "_memwb"});
            end
            6'b101011: begin
                step(rb(), ev(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0,0),
                     {nm, "_memadr"});
                repeat (sm)
                    step(1'b0, ev(1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,1,0,0),
                         {nm, "_memwr_stall"});
                step(1'b1, ev(1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,1,1,0),
                     {nm, "_memwr"});
            end
            6'b000100:
                step(rb(), ev(0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0,0,1,0),
                     {nm, "_branch"});
            6'b001000: begin
                step(rb(), ev(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0,0),
                     {nm, "_addiex"});
                step(rb(), ev(0,0,0,0,0,2'b00,0,2'b00,3'b010,0,0,1,0,1,0),
                     {nm, "_addiwb"});
            end
            6'b000010:
                step(rb(), ev(0,0,0,1,0,2'b10,0,2'b00,3'b010,0,0,0,0,1,0),
                     {nm, "_jump"});
            default: ;
        endcase
        lat = ref_latency(op) + sf + (is_mem ? sm : 0);
        chk_int(cyc, lat, {nm, "_cycles"});
        chk_int(done_at, lat - 1, {nm, "_final_cycle"});
        chk_int(ndone, legal ? 1 : 0, {nm, "_done_pulses"});
    endtask

    logic [18:0] rst_vec;
    logic [5:0]  ops [6];
    logic [5:0]  fns [6];

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b000000};
        rst_vec   = ev(1,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0,0,0);
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        #2;
        chk(obs, rst_vec, "reset_ready_high");
        @(posedge clk);
        #1;
        chk(obs, rst_vec, "reset_held");
        rst = 1'b0;

        run_instr(6'b000000, 6'b100000, 0, 0, "r_add");
        run_instr(6'b000000, 6'b100010, 0, 0, "r_sub");
        run_instr(6'b000000, 6'b100100, 0, 0, "r_and");
        run_instr(6'b000000, 6'b100101, 0, 0, "r_or");
        run_instr(6'b000000, 6'b101010, 0, 0, "r_slt");
        run_instr(6'b000000, 6'b000000, 0, 0, "r_unk");
        run_instr(6'b100011, 6'b000000, 0, 3, "lw_stall3");
        run_instr(6'b101011, 6'b000000, 0, 0, "sw");
        run_instr(6'b000100, 6'b000000, 0, 0, "beq");
        run_instr(6'b000010, 6'b000000, 0, 0, "j");
        run_instr(6'b001000, 6'b000000, 0, 0, "addi");
        run_instr(6'b111111, 6'b000000, 0, 0, "illegal");
        run_instr(6'b000000, 6'b100010, 2, 0, "r_fetch_stall");

        // Abort a load while it waits in the read state
        cyc = 0; ndone = 0; done_at = -1;
        opcode = 6'b100011;
        step(1'b1, ev(1,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0,0,0), "ab_fetch");
        step(1'b0, ev(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0,0,0), "ab_decode");
        step(1'b0, ev(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0,0,0), "ab_memadr");
        step(1'b0, ev(1,1,0,0,0,2'b00,0,2'b00,3'b010,0,0,0,0,0,0), "ab_memrd");
        rst = 1'b1;
        #1;
        chk(obs, rst_vec, "ab_reset_async");
        mem_ready = 1'b1;
        #1;
        chk(obs, rst_vec, "ab_reset_ready");
        @(posedge clk);
        #1;
        chk(obs, rst_vec, "ab_reset_edge");
        rst = 1'b0;
        run_instr(6'b000000, 6'b100101, 0, 0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                             : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                             : fns[$urandom_range(0, 5)];
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                      $sformatf("rnd%0d_op%b", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle MIPS controller: a Moore/Mealy FSM that sequences the shared datapath (single ALU, single unified instruction/data memory, register file) through fetch, decode, execute, memory and write-back steps, one instruction at a time. It sits beside the datapath and drives its enables and mux selects. It replaces single-cycle decoding for the multicycle core variant. Memory accesses use a request/ready handshake, so the controller tolerates multi-cycle memory latency.

## Interface
- Parameters: none; all encodings come from `mips_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load qualified by ALU zero (datapath ANDs it with zero).
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_control` out 3: ALU operation.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = memory data register, 0 = ALUOut.
- `reg_write` out 1: register file write enable.
- `mem_write` out 1: memory write (valid with `mem_req`).
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE on an unsupported opcode.

## Operation
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- `alu_op` is internal. It is 00 (add) in every state except EXECUTE, where it is 10 (funct), and BRANCH, where it is 01 (sub).
- ALU codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- funct decoding: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct decodes to ADD.
- Every output is 0 except as listed below for each state.
- FETCH: `mem_req`=1, `alu_src_b`=01. `ir_write`=`pc_write`=`mem_ready`. Advance to DECODE on `mem_ready`; otherwise hold.
- DECODE: `alu_src_b`=11. Next state by opcode: LW/SW -> MEMADR, R -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP. Any other opcode pulses `illegal_op` and returns to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: `mem_req`=1, `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Next is FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1. Hold until `mem_ready`. On `mem_ready`, `instr_done`=1 and next is FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00. Next is ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. Next is FETCH.
- BRANCH: `alu_src_a`=1, `branch`=1, `pc_src`=01, `instr_done`=1. Next is FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Next is ADDIWB.
- ADDIWB: `reg_write`=1, `instr_done`=1. Next is FETCH.
- JUMP: `pc_write`=1, `pc_src`=10, `instr_done`=1. Next is FETCH.

## Timing
- The state register is the only storage. All outputs are combinational from state, plus `mem_ready` and `opcode` where stated.
- Reset: state = FETCH, asynchronously. During and after reset, `mem_req`=1 and `alu_src_b`=01. All other outputs are 0 while `rst`=1: `ir_write`/`pc_write` are forced to 0 regardless of `mem_ready`.
- Reset asserted mid-instruction aborts it. No write enable asserts in the cycle after release unless FETCH sees `mem_ready`.
- Latency with `mem_ready` held at 1: R = 4 cycles, LW = 5, SW = 4, BEQ = 3, ADDI = 4, J = 3. Illegal opcode takes 2 cycles.
- Each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay stable while stalled.
- `mem_ready` is ignored outside the memory states.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from IR load until FETCH.

## Structure
- `mips_pkg`: opcode and funct constants, ALU control codes, `alu_op` codes, and the `state_t` enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP).
- Sub-module `alu_decoder`: combinational, maps (`alu_op`, `funct`) to `alu_control`. It is instantiated once.

## Test plan
- Reset: assert `rst` mid-MEMRD with `mem_ready`=0 -> state FETCH, `mem_req`=1, `alu_src_b`=01, all other outputs 0; after release with `mem_ready`=1, `ir_write`=`pc_write`=1 in the first cycle.
- R-type ADD (opcode 000000, funct 100000), `mem_ready`=1 -> `alu_control`=010 in EXECUTE; `reg_write`=1 and `reg_dst`=1 in cycle 4, with `instr_done` in the same cycle. Repeat for SUB/AND/OR/SLT expecting 110/000/001/111, and for funct 000000 expecting 010.
- LW with `mem_ready` low for 3 cycles in MEMRD -> 8 cycles total; `iord`=1 and `mem_req`=1 held throughout the stall; `mem_to_reg`=1 and `reg_write`=1 in the final cycle.
- SW, then BEQ, then J back-to-back -> SW: `mem_write`=1 with `iord`=1 in cycle 4. BEQ: `branch`=1, `pc_src`=01, `alu_control`=110 in cycle 3. J: `pc_write`=1, `pc_src`=10 in cycle 3. Exactly one `instr_done` pulse per instruction.
- ADDI (001000) -> `alu_src_b`=10 in cycle 3; `reg_write`=1 and `reg_dst`=0 in cycle 4.
- Illegal opcode 111111 -> `illegal_op` pulse in DECODE, no `reg_write`, `mem_write` or `pc_write`; FETCH on the next cycle.
